// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and op decode helpers.
package muldiv_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } md_state_e;

  // Even encodings are the signed flavours, the upper bit selects divide.
  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/pipeline_muldiv_unit_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
interface pipeline_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            flush;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, in1, in2, flush, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in1, in2, flush, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sign_unit.sv
// Sign handling around the unsigned core: operand magnitudes on entry,
// conditional negation of the 2*XLEN result (whole or per half) on exit.
module muldiv_sign_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  logic              i_signed,
  output logic [XLEN-1:0]   o_abs_a_c,
  output logic [XLEN-1:0]   o_abs_b_c,
  output logic              o_neg_a_c,
  output logic              o_neg_b_c,
  input  logic [2*XLEN-1:0] i_res,
  input  logic              i_neg_full,
  input  logic              i_neg_hi,
  input  logic              i_neg_lo,
  output logic [2*XLEN-1:0] o_res_c
);
  localparam int unsigned RW = 2 * XLEN;

  logic [RW-1:0]   w_res_neg;
  logic [XLEN-1:0] w_hi_neg;
  logic [XLEN-1:0] w_lo_neg;

  assign o_neg_a_c = i_signed & i_a[XLEN-1];
  assign o_neg_b_c = i_signed & i_b[XLEN-1];
  assign o_abs_a_c = o_neg_a_c ? ({XLEN{1'b0}} - i_a) : i_a;
  assign o_abs_b_c = o_neg_b_c ? ({XLEN{1'b0}} - i_b) : i_b;

  assign w_res_neg = {RW{1'b0}} - i_res;
  assign w_hi_neg  = {XLEN{1'b0}} - i_res[RW-1:XLEN];
  assign w_lo_neg  = {XLEN{1'b0}} - i_res[XLEN-1:0];

  // Products negate as one 2*XLEN value; quotient and remainder independently.
  always_comb begin
    o_res_c = i_res;
    if (i_neg_full) begin
      o_res_c = w_res_neg;
    end else begin
      if (i_neg_hi) o_res_c[RW-1:XLEN] = w_hi_neg;
      if (i_neg_lo) o_res_c[XLEN-1:0]  = w_lo_neg;
    end
  end
endmodule

// File: rtl/pipeline_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module pipeline_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_muldiv_unit_if.slave md
);
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned AW    = 2 * XLEN;

  md_state_e        r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [AW-1:0]    r_acc, w_acc_nx;
  logic [XLEN-1:0]  r_b, w_b_nx;
  logic [XLEN-1:0]  r_hi, w_hi_nx;
  logic [XLEN-1:0]  r_lo, w_lo_nx;
  logic             r_div, w_div_nx;
  logic             r_neg_q, w_neg_q_nx;
  logic             r_neg_r, w_neg_r_nx;
  logic             r_dz, w_dz_nx;
  logic             r_done, w_done_nx;
  logic             r_busy;

  logic             w_op_signed, w_op_div, w_fast;
  logic [XLEN-1:0]  w_abs_a, w_abs_b;
  logic             w_neg_a, w_neg_b;
  logic [AW-1:0]    w_res_fix, w_acc_init;
  logic [XLEN:0]    w_mul_sum, w_div_trial;
  logic             w_div_take;
  logic [AW-1:0]    w_mul_step, w_div_step;

  assign w_op_signed = op_is_signed(md.op);
  assign w_op_div    = op_is_div(md.op);

  muldiv_sign_unit #(.XLEN(XLEN)) u_sign (
    .i_a        (md.in1),
    .i_b        (md.in2),
    .i_signed   (w_op_signed),
    .o_abs_a_c  (w_abs_a),
    .o_abs_b_c  (w_abs_b),
    .o_neg_a_c  (w_neg_a),
    .o_neg_b_c  (w_neg_b),
    .i_res      (r_acc),
    .i_neg_full (~r_div & r_neg_q),
    .i_neg_hi   (r_div & r_neg_r),
    .i_neg_lo   (r_div & r_neg_q & ~r_dz),
    .o_res_c    (w_res_fix)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [AW-1:0] w_fast_prod;
  assign w_fast_prod = AW'(w_abs_a) * AW'(w_abs_b);
  assign w_fast      = ~w_op_div;
  assign w_acc_init  = w_op_div ? {{XLEN{1'b0}}, w_abs_a} : w_fast_prod;
`else
  assign w_fast      = 1'b0;
  assign w_acc_init  = w_op_div ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
`endif

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[AW-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}. A zero divisor always
  // "takes", leaving quotient all ones and the dividend magnitude as remainder.
  assign w_div_trial = r_acc[AW-1:XLEN-1] - {1'b0, r_b};
  assign w_div_take  = ~w_div_trial[XLEN] | r_dz;
  assign w_div_step  = w_div_take ? {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                                  : {r_acc[AW-2:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (md.flush) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (md.start) w_state_nx = w_fast ? FINISH : RUN;
        RUN:     if (r_cnt == CNT_W'(1)) w_state_nx = FINISH;
        FINISH:  w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nx   = r_cnt;
    w_acc_nx   = r_acc;
    w_b_nx     = r_b;
    w_div_nx   = r_div;
    w_neg_q_nx = r_neg_q;
    w_neg_r_nx = r_neg_r;
    w_dz_nx    = r_dz;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (md.mthi) w_hi_nx = md.wdata;
        if (md.mtlo) w_lo_nx = md.wdata;
        if (md.start && !md.flush) begin
          w_cnt_nx   = CNT_W'(XLEN);
          w_acc_nx   = w_acc_init;
          w_b_nx     = w_op_div ? w_abs_b : w_abs_a;
          w_div_nx   = w_op_div;
          w_neg_q_nx = w_neg_a ^ w_neg_b;
          w_neg_r_nx = w_neg_a;
          w_dz_nx    = w_op_div && (md.in2 == '0);
        end
      end
      RUN: begin
        if (!md.flush) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
          w_acc_nx = r_div ? w_div_step : w_mul_step;
        end
      end
      FINISH: begin
        if (!md.flush) begin
          w_hi_nx   = w_res_fix[AW-1:XLEN];
          w_lo_nx   = w_res_fix[XLEN-1:0];
          w_done_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_acc   <= w_acc_nx;
      r_b     <= w_b_nx;
      r_div   <= w_div_nx;
      r_neg_q <= w_neg_q_nx;
      r_neg_r <= w_neg_r_nx;
      r_dz    <= w_dz_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_done  <= w_done_nx;
      r_busy  <= (w_state_nx != IDLE);
    end
  end

  assign md.busy = r_busy;
  assign md.done = r_done;
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;
endmodule

// File: doc/pipeline_muldiv_unit.md
Name: pipeline_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the pipelined MIPS core. It adds MULT/MULTU/DIV/DIVU and the HI/LO architectural registers.
- Sits beside the ALU in EX. The EX stage issues an operation and the unit runs in the background.
- The hazard unit stalls mfhi/mflo while busy is high.
- Width is generic via XLEN.

Parameters:
- XLEN, 32, operand and HI/LO width. Must be even, >= 8.
- CNT_W, $clog2(XLEN+1), localparam: iteration counter width.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request operation; sampled only in IDLE
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- in1  input  XLEN  rs operand (multiplicand / dividend)
- in2  input  XLEN  rt operand (multiplier / divisor)
- flush  input  1  abort the in-flight operation (branch/jump squash of the issuing instruction)
- mthi  input  1  write HI from wdata
- mtlo  input  1  write LO from wdata
- wdata  input  XLEN  mthi/mtlo data
- busy  output  1  operation in flight (state != IDLE)
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register

Behaviour:
- Reset (asynchronous, any state): state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0.
- States: IDLE, RUN, FINISH.
- IDLE, start=1 (edge E0):
  - Latch |in1| and |in2| (absolute values for signed ops, raw values for unsigned ops).
  - Latch the result-sign flags and op.
  - counter=XLEN, go to RUN.
- RUN: one radix-2 step per edge.
  - MUL: shift-add into a 2*XLEN accumulator.
  - DIV: restoring shift-subtract.
  - counter decrements; at counter==1 the step completes and the state goes to FINISH.
  - RUN occupies edges E1..E_XLEN.
- FINISH (edge E_XLEN+1): apply the sign fix-up, write hi/lo, set done=1 for exactly one cycle, go to IDLE.
- Timing:
  - busy is high for XLEN+1 cycles after the start edge.
  - New hi/lo and done are visible XLEN+1 cycles after the start edge.
- MUL result: hi = upper XLEN bits, lo = lower XLEN bits of the full 2*XLEN product. Signed ops take the two's-complement product.
- DIV result: lo=quotient, hi=remainder.
  - Quotient truncates toward zero.
  - Remainder carries the sign of the dividend.
- Divide by zero (DIV or DIVU): hi=in1 unmodified, lo=all ones. No sign fix-up, no flag.
- DIV of most-negative value by -1: lo=most-negative value, hi=0. No exception.
- start while busy: ignored, no queueing.
- flush: synchronous.
  - Any state returns to IDLE with hi/lo unchanged and no done.
  - flush has priority over FINISH in the same cycle.
  - flush in IDLE together with start: start is suppressed.
- mthi/mtlo:
  - Applied at the edge only when in IDLE. Ignored while busy; the hazard unit must stall them.
  - Same edge as an accepted start: the write is applied, and the later result overwrites it.
- done is never asserted by mthi/mtlo.
- Operands are not required to stay stable after the start edge.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the full product combinationally at the start edge into the accumulator and go IDLE -> FINISH directly.
  - busy is high 1 cycle; hi/lo and done appear 1 cycle after the start edge.
  - DIV/DIVU are unchanged.
- Undefined: all operations are iterative as above.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - state enum IDLE/RUN/FINISH.
  - op-is-signed and op-is-divide helper constants.
- One combinational sub-module, muldiv_sign_unit: absolute value of the operands on entry, conditional two's-complement negation of the 2*XLEN result on exit.

Test Plan (XLEN=32):
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after the start edge; busy high 33 cycles.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/0 -> hi=0x00000007, lo=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mtlo 0x1234 in IDLE -> lo=0x1234 next cycle.
- DIVU 100/7 started; second start (and mthi) at cycle 5 ignored; flush at cycle 10 -> busy low next cycle, hi/lo hold 0x1234 history values, no done.
- reset asserted mid-RUN -> hi=lo=0, busy=0 immediately.
- With MULDIV_FAST_MUL_EN: MULT 6*7 -> lo=42, hi=0; done one cycle after the start edge.
